// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one synchronous VRAM between scanout (vid) and draw (drw) requesters and
// owns the frame-synchronous display page. Define VRAM_STARVE_GUARD_EN to build the draw starvation guard.
module vram_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 8,
    parameter int PAGE_W     = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_vid_req,
    input  logic [ADDR_W-1:0]        i_vid_addr,
    output logic                     o_vid_gnt,
    output logic [DATA_W-1:0]        o_vid_rdata,
    output logic                     o_vid_rvalid,
    input  logic                     i_drw_req,
    input  logic                     i_drw_we,
    input  logic [PAGE_W-1:0]        i_drw_page,
    input  logic [ADDR_W-1:0]        i_drw_addr,
    input  logic [DATA_W-1:0]        i_drw_wdata,
    output logic                     o_drw_gnt,
    output logic [DATA_W-1:0]        o_drw_rdata,
    output logic                     o_drw_rvalid,
    input  logic                     i_disp_page_wr,
    input  logic [PAGE_W-1:0]        i_disp_page_in,
    input  logic                     i_frame_start,
    output logic [PAGE_W-1:0]        o_cur_disp_page,
    output logic [PAGE_W+ADDR_W-1:0] o_mem_addr,
    output logic                     o_mem_we,
    output logic [DATA_W-1:0]        o_mem_wdata,
    input  logic [DATA_W-1:0]        i_mem_rdata
);

    logic              w_force_drw;
    logic              w_vid_hs;
    logic              w_drw_hs;
    logic              r_t1_rd;
    logic              r_t1_drw;
    logic              r_t2_rd;
    logic              r_t2_drw;
    logic [PAGE_W-1:0] r_pending_page;

`ifdef VRAM_STARVE_GUARD_EN
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] r_wait_cnt;

    assign w_force_drw = (r_wait_cnt == CNT_W'(STARVE_MAX));

    // Consecutive denied draw cycles; saturates so force_drw holds until the draw is served.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wait_cnt <= '0;
        end else if (!i_drw_req || w_drw_hs) begin
            r_wait_cnt <= '0;
        end else if (!w_force_drw) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end else begin
            r_wait_cnt <= r_wait_cnt;
        end
    end
`else
    logic w_unused_starve_max;

    assign w_force_drw         = 1'b0;
    assign w_unused_starve_max = (STARVE_MAX != 0);
`endif

    assign o_vid_gnt = reset & i_vid_req & ~w_force_drw;
    assign o_drw_gnt = reset & i_drw_req & (~i_vid_req | w_force_drw);
    assign w_vid_hs  = i_vid_req & o_vid_gnt;
    assign w_drw_hs  = i_drw_req & o_drw_gnt;

    // Register the winning access onto the VRAM port; idle cycles only drop the write enable.
    always_ff @(posedge clk) begin
        if (!reset) begin
            o_mem_addr  <= '0;
            o_mem_we    <= 1'b0;
            o_mem_wdata <= '0;
        end else if (w_vid_hs) begin
            o_mem_addr  <= {o_cur_disp_page, i_vid_addr};
            o_mem_we    <= 1'b0;
            o_mem_wdata <= o_mem_wdata;
        end else if (w_drw_hs) begin
            o_mem_addr  <= {i_drw_page, i_drw_addr};
            o_mem_we    <= i_drw_we;
            o_mem_wdata <= i_drw_wdata;
        end else begin
            o_mem_addr  <= o_mem_addr;
            o_mem_we    <= 1'b0;
            o_mem_wdata <= o_mem_wdata;
        end
    end

    // Tag pipeline: stage 1 follows the address cycle, stage 2 lines up with mem_rdata.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_t1_rd  <= 1'b0;
            r_t1_drw <= 1'b0;
            r_t2_rd  <= 1'b0;
            r_t2_drw <= 1'b0;
        end else begin
            r_t1_rd  <= w_vid_hs | (w_drw_hs & ~i_drw_we);
            r_t1_drw <= w_drw_hs;
            r_t2_rd  <= r_t1_rd;
            r_t2_drw <= r_t1_drw;
        end
    end

    // Route returning read data to its owner with a one-cycle valid strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            o_vid_rdata  <= '0;
            o_vid_rvalid <= 1'b0;
            o_drw_rdata  <= '0;
            o_drw_rvalid <= 1'b0;
        end else begin
            o_vid_rvalid <= r_t2_rd & ~r_t2_drw;
            o_drw_rvalid <= r_t2_rd & r_t2_drw;
            o_vid_rdata  <= (r_t2_rd && !r_t2_drw) ? i_mem_rdata : o_vid_rdata;
            o_drw_rdata  <= (r_t2_rd && r_t2_drw) ? i_mem_rdata : o_drw_rdata;
        end
    end

    // Page flips are staged in pending_page and only become visible at frame start.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pending_page  <= '0;
            o_cur_disp_page <= '0;
        end else begin
            r_pending_page <= i_disp_page_wr ? i_disp_page_in : r_pending_page;
            if (i_frame_start) begin
                o_cur_disp_page <= i_disp_page_wr ? i_disp_page_in : r_pending_page;
            end else begin
                o_cur_disp_page <= o_cur_disp_page;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: directed vectors push expected read data into per-owner
// queues; a negedge monitor pops and compares on every rvalid.
module tb_vram_arbiter;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;
    localparam int PAGE_W = 2;
    localparam int MA_W   = PAGE_W + ADDR_W;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              vid_req, vid_gnt, vid_rvalid;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_rdata;
    logic              drw_req, drw_we, drw_gnt, drw_rvalid;
    logic [PAGE_W-1:0] drw_page;
    logic [ADDR_W-1:0] drw_addr;
    logic [DATA_W-1:0] drw_wdata, drw_rdata;
    logic              disp_page_wr, frame_start;
    logic [PAGE_W-1:0] disp_page_in, cur_disp_page;
    logic [MA_W-1:0]   mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    logic [7:0] ram [0:(1<<MA_W)-1];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    exp_t vid_q[$];
    exp_t drw_q[$];

    vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PAGE_W(PAGE_W), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .i_vid_req(vid_req), .i_vid_addr(vid_addr), .o_vid_gnt(vid_gnt),
        .o_vid_rdata(vid_rdata), .o_vid_rvalid(vid_rvalid),
        .i_drw_req(drw_req), .i_drw_we(drw_we), .i_drw_page(drw_page), .i_drw_addr(drw_addr),
        .i_drw_wdata(drw_wdata), .o_drw_gnt(drw_gnt), .o_drw_rdata(drw_rdata),
        .o_drw_rvalid(drw_rvalid),
        .i_disp_page_wr(disp_page_wr), .i_disp_page_in(disp_page_in), .i_frame_start(frame_start),
        .o_cur_disp_page(cur_disp_page),
        .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port RAM model.
    always @(posedge clk) begin
        if (mem_we === 1'b1) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    function automatic logic [7:0] pat(input logic [16:0] a);
        pat = a[7:0] ^ a[15:8] ^ {7'd0, a[16]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every rvalid must match the oldest expected read of that owner, on its due cycle.
    always @(negedge clk) begin
        exp_t ev;
        exp_t ed;
        if (vid_rvalid === 1'b1) begin
            if (vid_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL vid_rvalid_unexpected: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                ev = vid_q.pop_front();
                chk("vid_rdata", 32'(vid_rdata), 32'(ev.data));
                chk("vid_rvalid_cycle", cyc, ev.due);
            end
        end
        if (drw_rvalid === 1'b1) begin
            if (drw_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL drw_rvalid_unexpected: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                ed = drw_q.pop_front();
                chk("drw_rdata", 32'(drw_rdata), 32'(ed.data));
                chk("drw_rvalid_cycle", cyc, ed.due);
            end
        end
    end

    initial begin
        int vi;
        int di;
        for (int i = 0; i < (1 << MA_W); i++) ram[i] = pat(17'(i));
        ram[17'h10010] = 8'h5A;
        reset = 1'b0;
        vid_req = 1'b0; vid_addr = '0;
        drw_req = 1'b0; drw_we = 1'b0; drw_page = '0; drw_addr = '0; drw_wdata = '0;
        disp_page_wr = 1'b0; disp_page_in = '0; frame_start = 1'b0;
        repeat (2) tick();

        // Reset state
        vid_req = 1'b1; drw_req = 1'b1;
        #1;
        chk("rst_vid_gnt", 32'(vid_gnt), 32'd0);
        chk("rst_drw_gnt", 32'(drw_gnt), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_vid_rvalid", 32'(vid_rvalid), 32'd0);
        chk("rst_drw_rvalid", 32'(drw_rvalid), 32'd0);
        chk("rst_cur_page", 32'(cur_disp_page), 32'd0);
        vid_req = 1'b0; drw_req = 1'b0;
        reset = 1'b1;
        tick();

        // Lone draw read, page 2 offset 0x0010
        drw_req = 1'b1; drw_we = 1'b0; drw_page = 2'd2; drw_addr = 15'h0010;
        #1;
        chk("t1_drw_gnt", 32'(drw_gnt), 32'd1);
        chk("t1_vid_gnt", 32'(vid_gnt), 32'd0);
        drw_q.push_back('{8'h5A, cyc + 3});
        tick();
        drw_req = 1'b0;
        chk("t1_mem_addr", 32'(mem_addr), 32'h10010);
        chk("t1_mem_we", 32'(mem_we), 32'd0);
        repeat (4) tick();

        // Both requesters held high
        vi = 0;
        di = 0;
`ifdef VRAM_STARVE_GUARD_EN
        for (int k = 0; k < 15; k++) begin
            vid_req = 1'b1; vid_addr = 15'(32'h0100 + vi);
            drw_req = 1'b1; drw_we = 1'b0; drw_page = 2'd1; drw_addr = 15'(32'h0200 + di);
            #1;
            if ((k % 5) == 4) begin
                chk("starve_drw_gnt", 32'(drw_gnt), 32'd1);
                chk("starve_vid_gnt", 32'(vid_gnt), 32'd0);
                drw_q.push_back('{pat({2'd1, drw_addr}), cyc + 3});
                di++;
            end else begin
                chk("starve_vid_gnt", 32'(vid_gnt), 32'd1);
                chk("starve_drw_gnt", 32'(drw_gnt), 32'd0);
                vid_q.push_back('{pat({2'd0, vid_addr}), cyc + 3});
                vi++;
            end
            tick();
        end
`else
        for (int k = 0; k < 100; k++) begin
            vid_req = 1'b1; vid_addr = 15'(32'h0100 + vi);
            drw_req = 1'b1; drw_we = 1'b0; drw_page = 2'd1; drw_addr = 15'(32'h0200 + di);
            #1;
            chk("strict_drw_gnt", 32'(drw_gnt), 32'd0);
            vid_q.push_back('{pat({2'd0, vid_addr}), cyc + 3});
            vi++;
            tick();
        end
`endif
        vid_req = 1'b0; drw_req = 1'b0;
        repeat (4) tick();

        // Display page flip staged mid-frame, applied at frame_start
        disp_page_wr = 1'b1; disp_page_in = 2'd3;
        tick();
        disp_page_wr = 1'b0;
        chk("page_hold0", 32'(cur_disp_page), 32'd0);
        tick();
        chk("page_hold1", 32'(cur_disp_page), 32'd0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("page_flip", 32'(cur_disp_page), 32'd3);
        vid_req = 1'b1; vid_addr = 15'h0123;
        #1;
        chk("page_vid_gnt", 32'(vid_gnt), 32'd1);
        vid_q.push_back('{pat({2'd3, 15'h0123}), cyc + 3});
        tick();
        vid_req = 1'b0;
        chk("page_mem_addr", 32'(mem_addr), 32'h18123);
        disp_page_wr = 1'b1; disp_page_in = 2'd1; frame_start = 1'b1;
        tick();
        disp_page_wr = 1'b0; frame_start = 1'b0;
        chk("page_same_cycle", 32'(cur_disp_page), 32'd1);
        repeat (4) tick();

        // Draw write then read-back of page 1 offset 0x7CFF
        drw_req = 1'b1; drw_we = 1'b1; drw_page = 2'd1; drw_addr = 15'h7CFF; drw_wdata = 8'hC3;
        #1;
        chk("wr_drw_gnt", 32'(drw_gnt), 32'd1);
        tick();
        drw_we = 1'b0; drw_wdata = 8'h00;
        chk("wr_mem_we", 32'(mem_we), 32'd1);
        chk("wr_mem_addr", 32'(mem_addr), 32'h0FCFF);
        chk("wr_mem_wdata", 32'(mem_wdata), 32'hC3);
        #1;
        chk("rd_drw_gnt", 32'(drw_gnt), 32'd1);
        drw_q.push_back('{8'hC3, cyc + 3});
        tick();
        drw_req = 1'b0;
        chk("rd_mem_we", 32'(mem_we), 32'd0);
        chk("rd_mem_addr", 32'(mem_addr), 32'h0FCFF);
        repeat (4) tick();

        // Reset one cycle after a vid read handshake: the in-flight read must vanish
        vid_req = 1'b1; vid_addr = 15'h0055;
        #1;
        chk("rr_vid_gnt", 32'(vid_gnt), 32'd1);
        tick();
        reset = 1'b0;
        #1;
        chk("rr_gnt_forced", 32'(vid_gnt), 32'd0);
        tick();
        chk("rr_mem_addr", 32'(mem_addr), 32'd0);
        chk("rr_mem_we", 32'(mem_we), 32'd0);
        chk("rr_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rr_vid_rdata", 32'(vid_rdata), 32'd0);
        chk("rr_drw_rdata", 32'(drw_rdata), 32'd0);
        chk("rr_cur_page", 32'(cur_disp_page), 32'd0);
        reset = 1'b1;
        #1;
        chk("rr_gnt_resume", 32'(vid_gnt), 32'd1);
        vid_q.push_back('{pat({2'd0, 15'h0055}), cyc + 3});
        tick();
        vid_req = 1'b0;

        // Bounded drain of outstanding reads
        for (int i = 0; i < 20 && (vid_q.size() != 0 || drw_q.size() != 0); i++) tick();
        repeat (3) tick();
        chk("vid_q_empty", 32'(vid_q.size()), 32'd0);
        chk("drw_q_empty", 32'(drw_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
